// File: rtl/present_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | present_pkg : S-box tables, FSM encoding and counter width shared by   |
// |               the PRESENT iterative cipher core.                       |
// | Rev 1.0                                                                 |
// +------------------------------------------------------------------------+
package present_pkg;

  localparam int CNT_W = 5;

  localparam logic [3:0] SBOX [16] = '{
    4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
    4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
  };

  localparam logic [3:0] INV_SBOX [16] = '{
    4'h5, 4'hE, 4'hF, 4'h8, 4'hC, 4'h1, 4'h2, 4'hD,
    4'hB, 4'h4, 4'h6, 4'h3, 4'h0, 4'h7, 4'h9, 4'hA
  };

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_KEXP = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  function automatic logic [3:0] sbox4(input logic [3:0] x);
    return SBOX[x];
  endfunction

  function automatic logic [3:0] inv_sbox4(input logic [3:0] x);
    return INV_SBOX[x];
  endfunction

endpackage
`default_nettype wire

// File: rtl/present_key_step.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | present_key_step : one forward or inverse PRESENT key-schedule step.   |
// |                    Purely combinational.                               |
// | Rev 1.0                                                                 |
// +------------------------------------------------------------------------+
module present_key_step
  import present_pkg::*;
#(
  parameter int KEY_WIDTH = 20,
  parameter int KEY_ROT   = 13,
  parameter int RC_LSB    = 0
) (
  input  logic [KEY_WIDTH-1:0] key,
  input  logic [CNT_W-1:0]     rc,
  input  logic                 inverse,
  output logic [KEY_WIDTH-1:0] next_key
);

  logic [KEY_WIDTH-1:0] w_rc_mask;
  logic [KEY_WIDTH-1:0] w_fwd_rot;
  logic [KEY_WIDTH-1:0] w_fwd_sub;
  logic [KEY_WIDTH-1:0] w_fwd_key;
  logic [KEY_WIDTH-1:0] w_inv_xor;
  logic [KEY_WIDTH-1:0] w_inv_sub;
  logic [KEY_WIDTH-1:0] w_inv_key;

  assign w_rc_mask = {{(KEY_WIDTH-CNT_W){1'b0}}, rc} << RC_LSB;

  // forward: rotate left, substitute top nibble, inject round counter
  assign w_fwd_rot = (key << KEY_ROT) | (key >> (KEY_WIDTH - KEY_ROT));
  assign w_fwd_sub = {sbox4(w_fwd_rot[KEY_WIDTH-1 -: 4]), w_fwd_rot[KEY_WIDTH-5:0]};
  assign w_fwd_key = w_fwd_sub ^ w_rc_mask;

  // inverse: the forward operations undone in reverse order
  assign w_inv_xor = key ^ w_rc_mask;
  assign w_inv_sub = {inv_sbox4(w_inv_xor[KEY_WIDTH-1 -: 4]), w_inv_xor[KEY_WIDTH-5:0]};
  assign w_inv_key = (w_inv_sub >> KEY_ROT) | (w_inv_sub << (KEY_WIDTH - KEY_ROT));

  assign next_key = inverse ? w_inv_key : w_fwd_key;

endmodule
`default_nettype wire

// File: rtl/present_iter_cipher.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | present_iter_cipher : iterative PRESENT-family block cipher, one round |
// |   per clock, on-the-fly key schedule. Define PRESENT_DECRYPT_EN to     |
// |   build the decrypt path (KEXP state, inverse key step, invS/invP).    |
// | Rev 1.0                                                                 |
// +------------------------------------------------------------------------+
module present_iter_cipher
  import present_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int KEY_WIDTH = 20,
  parameter int ROUNDS    = 7,
  parameter int KEY_ROT   = 13,
  parameter int RC_LSB    = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_mode,
  input  logic [WIDTH-1:0]     in_data,
  input  logic [KEY_WIDTH-1:0] in_key,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data
);

  localparam int               c_nib  = WIDTH / 4;
  localparam logic [CNT_W-1:0] c_last = CNT_W'(ROUNDS - 1);
  localparam logic [CNT_W-1:0] c_one  = CNT_W'(1);

  state_t               r_state;
  logic [WIDTH-1:0]     r_s;
  logic [KEY_WIDTH-1:0] r_kr;
  logic [CNT_W-1:0]     r_cnt;

  logic [WIDTH-1:0]     w_rk;
  logic [WIDTH-1:0]     w_enc_x;
  logic [WIDTH-1:0]     w_enc_sb;
  logic [WIDTH-1:0]     w_enc_out;
  logic [WIDTH-1:0]     w_next_rk;
  logic [KEY_WIDTH-1:0] w_next_kr;
  logic [CNT_W-1:0]     w_rc;
  logic                 w_key_inv;

  assign w_rk      = r_kr[KEY_WIDTH-1 -: WIDTH];
  assign w_next_rk = w_next_kr[KEY_WIDTH-1 -: WIDTH];
  // counter field of the step between K_cnt and K_cnt+1, used in both directions
  assign w_rc      = r_cnt + c_one;
  assign w_enc_x   = r_s ^ w_rk;

  present_key_step #(
    .KEY_WIDTH (KEY_WIDTH),
    .KEY_ROT   (KEY_ROT),
    .RC_LSB    (RC_LSB)
  ) u_key_step (
    .key      (r_kr),
    .rc       (w_rc),
    .inverse  (w_key_inv),
    .next_key (w_next_kr)
  );

`ifdef PRESENT_DECRYPT_EN
  logic             r_mode;
  logic [WIDTH-1:0] w_dec_ip;
  logic [WIDTH-1:0] w_dec_is;
  logic [WIDTH-1:0] w_dec_out;

  assign w_key_inv = (r_state == ST_RUN) && r_mode;
  assign w_dec_out = w_dec_is ^ w_next_rk;
`else
  logic w_unused_mode;

  assign w_key_inv     = 1'b0;
  assign w_unused_mode = in_mode;
`endif

  for (genvar n = 0; n < c_nib; n++) begin : g_sbox
    assign w_enc_sb[4*n +: 4] = sbox4(w_enc_x[4*n +: 4]);
`ifdef PRESENT_DECRYPT_EN
    assign w_dec_is[4*n +: 4] = inv_sbox4(w_dec_ip[4*n +: 4]);
`endif
  end

  // bit i travels to (i*WIDTH/4) mod (WIDTH-1); the MSB stays put
  for (genvar i = 0; i < WIDTH; i++) begin : g_perm
    localparam int c_dst = (i == WIDTH - 1) ? (WIDTH - 1) : ((i * (WIDTH / 4)) % (WIDTH - 1));
    assign w_enc_out[c_dst] = w_enc_sb[i];
`ifdef PRESENT_DECRYPT_EN
    assign w_dec_ip[i] = r_s[c_dst];
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_s     <= '0;
      r_kr    <= '0;
      r_cnt   <= '0;
`ifdef PRESENT_DECRYPT_EN
      r_mode  <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_s   <= in_data;
            r_kr  <= in_key;
            r_cnt <= '0;
`ifdef PRESENT_DECRYPT_EN
            r_mode  <= in_mode;
            r_state <= in_mode ? ST_KEXP : ST_RUN;
`else
            r_state <= ST_RUN;
`endif
          end
        end
`ifdef PRESENT_DECRYPT_EN
        ST_KEXP: begin
          r_kr <= w_next_kr;
          if (r_cnt == c_last) begin
            r_s     <= r_s ^ w_next_rk;
            r_state <= ST_RUN;
          end else begin
            r_cnt <= r_cnt + c_one;
          end
        end
`endif
        ST_RUN: begin
          r_kr <= w_next_kr;
`ifdef PRESENT_DECRYPT_EN
          if (r_mode) begin
            r_s <= w_dec_out;
            if (r_cnt == '0) begin
              r_state <= ST_DONE;
            end else begin
              r_cnt <= r_cnt - c_one;
            end
          end else
`endif
          if (r_cnt == c_last) begin
            r_s     <= w_enc_out ^ w_next_rk;
            r_state <= ST_DONE;
          end else begin
            r_s   <= w_enc_out;
            r_cnt <= r_cnt + c_one;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_DONE);
  assign out_data  = out_valid ? r_s : '0;

endmodule
`default_nettype wire

// File: tb/tb_present_iter_cipher.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_present_iter_cipher : directed vectors for present_iter_cipher,     |
// |   default 16/20/7 core plus a PRESENT-80 sized instance.               |
// | Rev 1.0                                                                 |
// +------------------------------------------------------------------------+
module tb_present_iter_cipher;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_mode, out_valid, out_ready;
  logic [15:0] in_data, out_data;
  logic [19:0] in_key;

  logic        v_in_valid, v_in_ready, v_in_mode, v_out_valid, v_out_ready;
  logic [63:0] v_in_data, v_out_data;
  logic [79:0] v_in_key;

  int n_vectors     = 0;
  int n_miscompares = 0;

  always #5 clk = ~clk;

  present_iter_cipher dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mode   (in_mode),
    .in_data   (in_data),
    .in_key    (in_key),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  present_iter_cipher #(
    .WIDTH     (64),
    .KEY_WIDTH (80),
    .ROUNDS    (31),
    .KEY_ROT   (61),
    .RC_LSB    (15)
  ) dut64 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (v_in_valid),
    .in_ready  (v_in_ready),
    .in_mode   (v_in_mode),
    .in_data   (v_in_data),
    .in_key    (v_in_key),
    .out_valid (v_out_valid),
    .out_ready (v_out_ready),
    .out_data  (v_out_data)
  );

  task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vectors++;
    if (got !== exp) begin
      n_miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issue one request on the 16-bit core; lat counts clocks from the accept edge
  task automatic do_req(input string tag, input logic mode, input logic [15:0] data,
                        input logic [19:0] key, input bit pop,
                        output logic [15:0] res, output int lat);
    lat = 0;
    check_vec({tag, " in_ready"}, 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    in_mode  = mode;
    in_data  = data;
    in_key   = key;
    @(negedge clk);
    in_valid = 1'b0;
    in_mode  = ~mode;
    in_data  = ~data;
    in_key   = ~key;
    for (int k = 1; k <= 80; k++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = k;
        break;
      end
    end
    res = out_data;
    if (pop) begin
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
    end
  endtask

  task automatic run_req(input string tag, input logic mode, input logic [15:0] data,
                         input logic [19:0] key, input logic [15:0] exp, input int exp_lat);
    logic [15:0] res;
    int          lat;
    do_req(tag, mode, data, key, 1'b1, res, lat);
    check_vec({tag, " latency"}, 64'(lat), 64'(exp_lat));
    check_vec({tag, " data"}, 64'(res), 64'(exp));
  endtask

  initial begin
    logic [15:0] res;
    int          lat;
    int          lat64;

    rst         = 1'b1;
    in_valid    = 1'b0;
    in_mode     = 1'b0;
    in_data     = '0;
    in_key      = '0;
    out_ready   = 1'b0;
    v_in_valid  = 1'b0;
    v_in_mode   = 1'b0;
    v_in_data   = '0;
    v_in_key    = '0;
    v_out_ready = 1'b0;

    repeat (2) @(negedge clk);
    check_vec("rst in_ready", 64'(in_ready), 64'd1);
    check_vec("rst out_valid", 64'(out_valid), 64'd0);
    check_vec("rst out_data", 64'(out_data), 64'd0);
    check_vec("rst64 out_valid", 64'(v_out_valid), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check_vec("post-rst in_ready", 64'(in_ready), 64'd1);

    // PRESENT-80 reference vector: plaintext 0, key 0
    v_in_valid = 1'b1;
    @(negedge clk);
    v_in_valid = 1'b0;
    lat64 = 0;
    for (int k = 1; k <= 80; k++) begin
      @(negedge clk);
      if (v_out_valid) begin
        lat64 = k;
        break;
      end
    end
    check_vec("p80 latency", 64'(lat64), 64'd31);
    check_vec("p80 data", v_out_data, 64'h5579C1387B228445);
    v_out_ready = 1'b1;
    @(negedge clk);
    v_out_ready = 1'b0;
    check_vec("p80 in_ready", 64'(v_in_ready), 64'd1);

    run_req("enc 0000/00000", 1'b0, 16'h0000, 20'h00000, 16'h76B0, 7);
    run_req("enc FFFF/00000", 1'b0, 16'hFFFF, 20'h00000, 16'h594A, 7);

`ifdef PRESENT_DECRYPT_EN
    run_req("dec 76B0/00000", 1'b1, 16'h76B0, 20'h00000, 16'h0000, 14);
    run_req("dec 594A/00000", 1'b1, 16'h594A, 20'h00000, 16'hFFFF, 14);
    do_req("enc BEEF/ABCDE", 1'b0, 16'hBEEF, 20'hABCDE, 1'b1, res, lat);
    check_vec("enc BEEF latency", 64'(lat), 64'd7);
    run_req("dec BEEF roundtrip", 1'b1, res, 20'hABCDE, 16'hBEEF, 14);
`else
    run_req("mode1 0000/00000", 1'b1, 16'h0000, 20'h00000, 16'h76B0, 7);
    run_req("mode1 FFFF/00000", 1'b1, 16'hFFFF, 20'h00000, 16'h594A, 7);
`endif

    // backpressure: result held while a competing request waits
    do_req("bp", 1'b0, 16'hFFFF, 20'h00000, 1'b0, res, lat);
    check_vec("bp latency", 64'(lat), 64'd7);
    in_valid = 1'b1;
    in_mode  = 1'b0;
    in_data  = 16'h1234;
    in_key   = 20'h55555;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check_vec("bp out_valid", 64'(out_valid), 64'd1);
      check_vec("bp out_data", 64'(out_data), 64'h594A);
      check_vec("bp in_ready", 64'(in_ready), 64'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check_vec("bp release in_ready", 64'(in_ready), 64'd1);
    check_vec("bp release out_valid", 64'(out_valid), 64'd0);
    repeat (10) @(negedge clk);
    check_vec("bp no stray accept", 64'(out_valid), 64'd0);

    // asynchronous reset while cnt==3
    in_valid = 1'b1;
    in_mode  = 1'b0;
    in_data  = 16'hFFFF;
    in_key   = 20'h00000;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_vec("mid-run in_ready", 64'(in_ready), 64'd0);
    rst = 1'b1;
    #1;
    check_vec("async rst in_ready", 64'(in_ready), 64'd1);
    check_vec("async rst out_valid", 64'(out_valid), 64'd0);
    check_vec("async rst out_data", 64'(out_data), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check_vec("discarded request", 64'(out_valid), 64'd0);
    run_req("post-abort enc", 1'b0, 16'h0000, 20'h00000, 16'h76B0, 7);

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
`default_nettype wire
